// File: rtl/serial_paralelo_rx_if.sv
// rtl/serial_paralelo_rx_if.sv - serial receiver bit input and aligned word output bundle
interface serial_paralelo_rx_if;
  logic       enb;
  logic       entrada;
  logic [9:0] salidas;
  logic       valido;
  logic       es_coma;
  logic       alineado;

  // Serial source side: drives the bit stream, observes recovered words
  modport master (
    output enb,
    output entrada,
    input  salidas,
    input  valido,
    input  es_coma,
    input  alineado
  );

  // Receiver side
  modport slave (
    input  enb,
    input  entrada,
    output salidas,
    output valido,
    output es_coma,
    output alineado
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// rtl/serial_paralelo_rx.sv - 10-bit deserialiser with K28.5 comma word alignment
module serial_paralelo_rx #(
  parameter int              ANCHO         = 10,
  parameter logic [ANCHO-1:0] COMA_NEG     = 10'h0FA,
  parameter logic [ANCHO-1:0] COMA_POS     = 10'h305,
  parameter int              COMAS_ALINEAR = 3,
  parameter int              ERRORES_MAX   = 2
) (
  input logic                 clk,
  input logic                 rst,
  serial_paralelo_rx_if.slave bus
);

  typedef enum logic [1:0] {BUSCAR, VERIFICAR, ALINEADO} estado_t;

  localparam logic [3:0] ULTIMO = 4'(ANCHO - 1);
  localparam logic [3:0] C_COMAS = 4'(COMAS_ALINEAR);
  localparam logic [3:0] C_ERR = 4'(ERRORES_MAX);

  estado_t          r_estado;
  estado_t          w_estado_nxt;
  logic [ANCHO-1:0] r_sr;
  logic [ANCHO-1:0] r_salidas;
  logic [3:0]       r_cnt;
  logic [3:0]       r_ncomas;
  logic [3:0]       r_nerr;
  logic             r_valido;
  logic             r_es_coma;

  logic [ANCHO-1:0] w_salidas_nxt;
  logic [3:0]       w_cnt_nxt;
  logic [3:0]       w_ncomas_nxt;
  logic [3:0]       w_nerr_nxt;
  logic             w_valido_nxt;
  logic             w_es_coma_nxt;
  logic             w_coma;
  logic             w_limite;

  // Comma and word boundary are judged on the contents before the shift
  assign w_coma   = (r_sr == COMA_NEG) || (r_sr == COMA_POS);
  assign w_limite = (r_cnt == 4'd0);

  // Next-state and next-datapath decisions for one enabled bit
  always_comb begin
    w_estado_nxt  = r_estado;
    w_cnt_nxt     = (r_cnt == ULTIMO) ? 4'd0 : r_cnt + 4'd1;
    w_ncomas_nxt  = r_ncomas;
    w_nerr_nxt    = r_nerr;
    w_salidas_nxt = r_salidas;
    w_valido_nxt  = 1'b0;
    w_es_coma_nxt = r_es_coma;
    case (r_estado)
      BUSCAR: begin
        if (w_coma) begin
          w_cnt_nxt    = 4'd1;
          w_ncomas_nxt = 4'd1;
          w_estado_nxt = VERIFICAR;
        end
      end
      VERIFICAR: begin
        if (w_coma && w_limite) begin
          w_ncomas_nxt = r_ncomas + 4'd1;
          if (r_ncomas + 4'd1 == C_COMAS) begin
            w_estado_nxt = ALINEADO;
            w_nerr_nxt   = 4'd0;
          end
        end else if (w_coma) begin
          // Comma off the assumed phase: trust the newest one instead
          w_cnt_nxt    = 4'd1;
          w_ncomas_nxt = 4'd1;
        end
      end
      ALINEADO: begin
        if (w_limite) begin
          w_salidas_nxt = r_sr;
          w_valido_nxt  = 1'b1;
          w_es_coma_nxt = w_coma;
          if (w_coma) begin
            w_nerr_nxt = 4'd0;
          end
        end else if (w_coma) begin
          if (r_nerr + 4'd1 == C_ERR) begin
            w_estado_nxt = BUSCAR;
            w_nerr_nxt   = 4'd0;
            w_ncomas_nxt = 4'd0;
          end else begin
            w_nerr_nxt = r_nerr + 4'd1;
          end
        end
      end
      default: begin
        w_estado_nxt = BUSCAR;
      end
    endcase
  end

  // Alignment state register; frozen while the bit enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado <= BUSCAR;
    end else if (bus.enb) begin
      r_estado <= w_estado_nxt;
    end
  end

  // Shift register, counters and output word; a stalled edge only drops valido
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr      <= '0;
      r_cnt     <= 4'd0;
      r_ncomas  <= 4'd0;
      r_nerr    <= 4'd0;
      r_salidas <= '0;
      r_valido  <= 1'b0;
      r_es_coma <= 1'b0;
    end else if (bus.enb) begin
      r_sr      <= {r_sr[ANCHO-2:0], bus.entrada};
      r_cnt     <= w_cnt_nxt;
      r_ncomas  <= w_ncomas_nxt;
      r_nerr    <= w_nerr_nxt;
      r_salidas <= w_salidas_nxt;
      r_valido  <= w_valido_nxt;
      r_es_coma <= w_es_coma_nxt;
    end else begin
      r_valido  <= 1'b0;
    end
  end

  assign bus.salidas  = r_salidas;
  assign bus.valido   = r_valido;
  assign bus.es_coma  = r_es_coma;
  assign bus.alineado = (r_estado == ALINEADO);

endmodule
